// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and issues single-outstanding imem reads.
// It presents a registered {pc, pc+4, instr, valid} bundle to IF/ID and squashes wrong-path fetches on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_id_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } ifid_t;

  localparam ifid_t IFID_EMPTY = '{valid: 1'b0, pc: 32'h0, pc_plus4: 32'h0, instr: NOP_INSTR};
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifid_t       out_q, out_d;

  logic [31:0] redir_pc;
  logic        req_fire;

  assign redir_pc = redirect_pc & ALIGN_MASK;
  assign req_fire = (state_q == S_REQ) && imem_req_ready;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC & ALIGN_MASK;
      out_q   <= IFID_EMPTY;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
    end
  end

  // Next-state and datapath update; redirect outranks everything except in IDLE
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          // An accepted request still owes a response that must be dropped
          state_d = req_fire ? S_DROP : S_REQ;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          out_d.valid    = 1'b1;
          out_d.pc       = pc_q;
          out_d.pc_plus4 = pc_q + 32'd4;
          out_d.instr    = imem_rsp_data;
          pc_d           = pc_q + 32'd4;
          state_d        = S_HOLD;
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
        end else if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redir_pc;
          out_d   = IFID_EMPTY;
          state_d = S_REQ;
        end else if (if_id_write) begin
          out_d   = IFID_EMPTY;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
        out_d   = IFID_EMPTY;
      end
    endcase
  end

  always_comb begin
    imem_req_valid = (state_q == S_REQ);
    imem_addr      = pc_q & ALIGN_MASK;
    if_valid       = out_q.valid;
    if_pc          = out_q.pc;
    if_pc_plus4    = out_q.pc_plus4;
    if_instr       = out_q.instr;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model plus scoreboard queues for request addresses
// and consumed IF/ID bundles, with directed checks for stall, redirect, wrap and reset.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_id_write = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc, if_pc_plus4, if_instr;

  // second instance exercises a non-zero RESET_PC and PC wrap
  logic        rst2 = 1'b0;
  logic        write2 = 1'b0;
  logic        req2;
  logic [31:0] addr2;
  logic        rsp2_q = 1'b0;
  logic [31:0] data2_q = 32'h0;
  logic        valid2;
  logic [31:0] pc2, pc4_2, instr2;

  int checks = 0;
  int errors = 0;
  int lat = 1;

  logic [31:0] exp_addr_q[$];
  logic [95:0] exp_pres_q[$];

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .reset(reset), .if_id_write(if_id_write),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_instr(if_instr)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(rst2), .if_id_write(write2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(req2), .imem_req_ready(1'b1),
    .imem_addr(addr2), .imem_rsp_valid(rsp2_q),
    .imem_rsp_data(data2_q), .if_valid(valid2), .if_pc(pc2),
    .if_pc_plus4(pc4_2), .if_instr(instr2)
  );

  // Memory model: data = {8'hAB, addr[23:0]}, response lat cycles after acceptance
  logic        pend_q = 1'b0;
  int          cnt_q = 0;
  logic [31:0] maddr_q = 32'h0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= 1'b0;
      cnt_q  <= 0;
    end else begin
      if (pend_q && cnt_q == 0) pend_q <= 1'b0;
      else if (pend_q) cnt_q <= cnt_q - 1;
      if (imem_req_valid && imem_req_ready) begin
        pend_q  <= 1'b1;
        cnt_q   <= lat - 1;
        maddr_q <= imem_addr;
      end
    end
  end
  assign imem_rsp_valid = pend_q && (cnt_q == 0);
  assign imem_rsp_data  = {8'hAB, maddr_q[23:0]};

  always @(posedge clk or negedge rst2) begin
    if (!rst2) rsp2_q <= 1'b0;
    else begin
      rsp2_q  <= req2;
      data2_q <= {8'hAB, addr2[23:0]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops expected addresses on each handshake and bundles on each consume
  always @(negedge clk) begin
    if (imem_req_valid && imem_req_ready) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
      end else begin
        logic [31:0] ea;
        ea = exp_addr_q.pop_front();
        if (imem_addr !== ea) begin
          errors++;
          $display("FAIL req_addr: got %h expected %h", imem_addr, ea);
        end
      end
    end
    if (if_valid && if_id_write && !redirect_valid) begin
      checks++;
      if (exp_pres_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_consume: got pc %h expected nothing", if_pc);
      end else begin
        logic [95:0] ep;
        ep = exp_pres_q.pop_front();
        if ({if_pc, if_pc_plus4, if_instr} !== ep) begin
          errors++;
          $display("FAIL consume: got %h/%h/%h expected %h/%h/%h", if_pc, if_pc_plus4,
                   if_instr, ep[95:64], ep[63:32], ep[31:0]);
        end
      end
    end
  end

  task automatic push_pres(input logic [31:0] pc);
    exp_pres_q.push_back({pc, pc + 32'd4, 8'hAB, pc[23:0]});
  endtask

  task automatic wait_valid(input string name, input int max);
    bit found = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (if_valid) begin found = 1; break; end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s: got no if_valid expected if_valid within %0d cycles", name, max);
    end
  endtask

  // Returns just after the edge at which a request was accepted (FSM now in WAIT)
  task automatic wait_hs(input string name, input int max);
    bit found = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin found = 1; break; end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL %s: got no handshake expected one within %0d cycles", name, max);
    end
    @(posedge clk); #1;
  endtask

  task automatic consume(input string name);
    wait_valid(name, 20);
    @(posedge clk); #1 if_id_write = 1'b1;
    @(posedge clk); #1 if_id_write = 1'b0;
  endtask

  initial begin
    // Reset state, no requests while reset is low
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc4", if_pc_plus4, 32'h0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_req", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst2_addr", addr2, 32'hFFFF_FFFC);
    chk("rst2_req", {31'b0, req2}, 32'h0);

    // Sequential fetch 0, 4, 8
    exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8);
    push_pres(32'h0); push_pres(32'h4);
    @(posedge clk); #1 reset = 1'b1;
    consume("fetch0");
    consume("fetch4");

    // Stall with instruction at 0x8 held
    wait_valid("stall_wait", 20);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, if_valid}, 32'h1);
      chk("stall_pc", if_pc, 32'h8);
      chk("stall_instr", if_instr, 32'hAB00_0008);
      chk("stall_req", {31'b0, imem_req_valid}, 32'h0);
      @(negedge clk);
    end

    // Release stall; 0xC must be requested the next cycle, then redirect in WAIT
    lat = 3;
    push_pres(32'h8);
    exp_addr_q.push_back(32'hC);
    exp_addr_q.push_back(32'h100);
    consume("stall_release");
    wait_hs("next_req_after_stall", 1);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_valid("redir_wait", 30);
    chk("redir_wait_pc", if_pc, 32'h100);
    chk("redir_wait_instr", if_instr, 32'hAB00_0100);

    // Redirect coincident with response, unaligned target
    lat = 1;
    push_pres(32'h100);
    exp_addr_q.push_back(32'h104);
    exp_addr_q.push_back(32'h200);
    consume("fetch100");
    wait_hs("hs104", 5);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("coinc_valid", {31'b0, if_valid}, 32'h0);
    chk("coinc_addr", imem_addr, 32'h200);
    wait_valid("coinc_fetch", 10);
    chk("coinc_pc", if_pc, 32'h200);
    chk("coinc_pc4", if_pc_plus4, 32'h204);
    chk("coinc_instr", if_instr, 32'hAB00_0200);

    // Redirect in HOLD while stalled
    exp_addr_q.push_back(32'h300);
    @(posedge clk); #1 redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    chk("hold_redir_valid", {31'b0, if_valid}, 32'h0);
    chk("hold_redir_instr", if_instr, NOP);
    chk("hold_redir_req", {31'b0, imem_req_valid}, 32'h1);
    chk("hold_redir_addr", imem_addr, 32'h300);

    // Reset asserted while in WAIT
    push_pres(32'h300);
    exp_addr_q.push_back(32'h304);
    lat = 3;
    consume("fetch300");
    wait_hs("hs304", 5);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", {31'b0, if_valid}, 32'h0);
    chk("arst_instr", if_instr, NOP);
    chk("arst_pc", if_pc, 32'h0);
    chk("arst_req", {31'b0, imem_req_valid}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    lat = 1;
    exp_addr_q.push_back(32'h0);
    push_pres(32'h0);
    @(posedge clk); #1 reset = 1'b1;
    wait_valid("after_arst", 10);
    imem_req_ready = 1'b0;
    consume("after_arst_consume");

    // PC wrap on the RESET_PC=0xFFFF_FFFC instance
    @(posedge clk); #1 rst2 = 1'b1;
    begin
      bit found = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (valid2) begin found = 1; break; end
      end
      chk("wrap_found", {31'b0, found}, 32'h1);
    end
    chk("wrap_pc", pc2, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_2, 32'h0);
    chk("wrap_instr", instr2, 32'hABFF_FFFC);
    @(posedge clk); #1 write2 = 1'b1;
    @(posedge clk); #1 write2 = 1'b0;
    @(negedge clk);
    chk("wrap_req", {31'b0, req2}, 32'h1);
    chk("wrap_addr", addr2, 32'h0);

    repeat (3) @(negedge clk);
    chk("addr_q_empty", exp_addr_q.size(), 32'h0);
    chk("pres_q_empty", exp_pres_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
